// File: rtl/mo_mul_arbiter.sv
// mo_mul_arbiter: shares one pipelined Montgomery multiplier (mo_mul) among NREQ
// requesters. One issue per cycle, an owner tag rides alongside every product,
// and each result is handed back to its owner as a one-cycle rsp_valid pulse.
// Build option: define MO_MUL_ARB_FIXPRIO_EN for fixed priority (lowest index
// wins); otherwise round-robin arbitration is used.
//
// mo_mul computes r == a*b*2^-WIDTH (mod Q) in centred form, one bit of a per
// stage. It is a free-running datapath without reset or stall; all control
// state (validity, ownership) lives in the arbiter's tag pipeline.

module mo_mul #(
  parameter int WIDTH = 12,
  parameter int Q     = 3329
) (
  input  logic                    clk,
  input  logic [WIDTH-1:0]        a_i,
  input  logic [WIDTH-1:0]        b_i,
  output logic signed [WIDTH:0]   r_o
);

  localparam logic [WIDTH:0] Q_T       = (WIDTH+1)'(Q);
  localparam logic [WIDTH:0] Q_HALF_UP = (WIDTH+1)'((Q + 1) / 2);
  localparam logic [WIDTH:0] Q_HALF_DN = (WIDTH+1)'((Q - 1) / 2);

  logic [WIDTH:0] t_out_q;
  logic [WIDTH:0] r_pos;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_stage
      // Each stage consumes bit 0 of its remaining 'a' bits, so the operand
      // shrinks by one bit per stage and nothing unused is carried along.
      localparam int AW = WIDTH - gi;
      logic [AW-1:0]    a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH:0]   t_in;
      logic [WIDTH+1:0] s;
      logic [WIDTH:0]   t_next;

      if (gi == 0) begin : g_src
        assign a_in = a_i;
        assign b_in = b_i;
        assign t_in = '0;
      end else begin : g_src
        logic [AW-1:0]    a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH:0]   t_q;
        // Capture the previous stage's partial sum and the operand bits still needed
        always_ff @(posedge clk) begin
          a_q <= g_stage[gi-1].a_in[AW:1];
          b_q <= g_stage[gi-1].b_in;
          t_q <= g_stage[gi-1].t_next;
        end
        assign a_in = a_q;
        assign b_in = b_q;
        assign t_in = t_q;
      end

      // t stays <= 2Q, so t + b + Q < 2^(WIDTH+2) for any Q < 2^WIDTH.
      assign s = {1'b0, t_in} + (a_in[0] ? {2'b00, b_in} : '0);
      // (s + Q) / 2 for odd s (Q odd) equals floor(s/2) + (Q+1)/2.
      assign t_next = s[WIDTH+1:1] + (s[0] ? Q_HALF_UP : '0);
    end
  endgenerate

  // Output register: the last stage result lands here
  always_ff @(posedge clk) begin
    t_out_q <= g_stage[WIDTH-1].t_next;
  end

  // Fold 0..2Q into 0..Q, then centre into (-Q/2, Q/2]; Q itself maps to 0.
  assign r_pos = (t_out_q >= Q_T) ? (t_out_q - Q_T) : t_out_q;
  assign r_o   = (r_pos > Q_HALF_DN) ? $signed(r_pos - Q_T) : $signed(r_pos);

endmodule

module mo_mul_arbiter #(
  parameter  int WIDTH = 12,
  parameter  int NREQ  = 2,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         rsp_valid,
  output logic signed [WIDTH:0]   rsp_data,
  output logic                    busy
);

  localparam int Q = 3329;

  logic                  grant_any;
  logic [IDW-1:0]        grant_id;
  logic [WIDTH-1:0]      a_q, a_d;
  logic [WIDTH-1:0]      b_q, b_d;
  logic [WIDTH:0]        tag_v_q;
  logic [IDW-1:0]        tag_id_q [0:WIDTH];
  logic signed [WIDTH:0] mul_r;

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic logic [IDW-1:0] lowest(input logic [NREQ-1:0] v);
    logic [IDW-1:0] r;
    r = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) r = IDW'(i);
    end
    return r;
  endfunction

  assign grant_any = |req_valid;

`ifdef MO_MUL_ARB_FIXPRIO_EN
  // Fixed priority: lowest requesting index wins
  always_comb begin
    grant_id = lowest(req_valid);
  end
`else
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] mask_hi;
  logic [NREQ-1:0] masked_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_mask
      assign mask_hi[gi] = (IDW'(gi) > ptr_q);
    end
  endgenerate

  assign masked_valid = req_valid & mask_hi;

  // Round-robin: first requester above the last winner, else wrap to the lowest
  always_comb begin
    grant_id = (|masked_valid) ? lowest(masked_valid) : lowest(req_valid);
    ptr_d    = grant_any ? grant_id : ptr_q;
  end

  // Pointer remembers the last winner; idle cycles leave it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= IDW'(NREQ - 1);
    else     ptr_q <= ptr_d;
  end
`endif

  genvar gr;
  generate
    for (gr = 0; gr < NREQ; gr++) begin : g_port
      assign req_ready[gr] = grant_any && (grant_id == IDW'(gr));
      assign rsp_valid[gr] = tag_v_q[WIDTH] && (tag_id_q[WIDTH] == IDW'(gr));
    end
  endgenerate

  // Select the winner's operands; hold the stage-0 registers when idle
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        a_d = req_a[i*WIDTH +: WIDTH];
        b_d = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Stage-0 operand registers feeding the multiplier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // Tag pipeline: one {valid,id} per multiplier stage, bubbles on idle cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_q <= '0;
      for (int i = 0; i <= WIDTH; i++) tag_id_q[i] <= '0;
    end else begin
      tag_v_q     <= {tag_v_q[WIDTH-1:0], grant_any};
      tag_id_q[0] <= grant_id;
      for (int i = 1; i <= WIDTH; i++) tag_id_q[i] <= tag_id_q[i-1];
    end
  end

  mo_mul #(
    .WIDTH (WIDTH),
    .Q     (Q)
  ) u_mo_mul (
    .clk (clk),
    .a_i (a_q),
    .b_i (b_q),
    .r_o (mul_r)
  );

  assign rsp_data = mul_r;
  assign busy     = |tag_v_q;

endmodule

// File: tb/tb_mo_mul_arbiter.sv
// Scoreboard bench for mo_mul_arbiter (WIDTH=12, NREQ=3, Q=3329).
// Accepts push the expected {owner, product, cycle}; a monitor pops on rsp_valid.
module tb_mo_mul_arbiter;
  localparam int WIDTH = 12;
  localparam int NREQ  = 3;
  localparam int Q     = 3329;
  localparam int LAT   = 13;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic signed [WIDTH:0] rsp_data;
  logic                  busy;

  always #5 clk = ~clk;

  mo_mul_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  typedef struct { int id; int data; int cyc; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rinv    = 0;
  int n_acc   = 0;
  logic [NREQ-1:0] acc_mask = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Golden model: a*b*2^-12 mod Q, centred into (-Q/2, Q/2]
  function automatic int model(input int a, input int b);
    int r;
    r = (((a * b) % Q) * rinv) % Q;
    if (r > Q / 2) r -= Q;
    return r;
  endfunction

  // Monitor: record accepts, pop and compare on every response
  always @(negedge clk) begin
    if (!rst) begin
      acc_mask = req_valid & req_ready;
      check("ready_legal", (!$onehot0(req_ready) || ((req_ready & ~req_valid) != '0)) ? 1 : 0, 0);
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i]) begin
          sb.push_back('{i, model(int'(req_a[i*WIDTH +: WIDTH]), int'(req_b[i*WIDTH +: WIDTH])), cyc});
          n_acc++;
          $display("[TB] accept id=%0d a=%0d b=%0d cycle=%0d", i, req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH], cyc);
        end
      end
      if (rsp_valid !== '0) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected: rsp_valid=%b with nothing outstanding (cycle %0d)", rsp_valid, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_id", rsp_valid, 1 << mon_e.id);
          check("rsp_data", rsp_data, mon_e.data);
          check("rsp_latency", cyc - mon_e.cyc, LAT);
        end
      end
    end else begin
      acc_mask = '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input int a, input int b);
    req_valid[i] = v;
    req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  task automatic do_reset();
    req_valid = '0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    repeat (2) begin
      @(negedge clk);
      check("busy_in_reset", busy, 0);
      check("rsp_in_reset", rsp_valid, 0);
      check("ready_in_reset", req_ready, 0);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (sb.size() != 0 && g < 40) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    check(name, sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    int guard;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int r = 1; r < Q; r++) begin
      if ((r * 4096) % Q == 1) begin
        rinv = r;
        break;
      end
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_rsp", rsp_valid, 0);
    check("reset_ready", req_ready, 0);
    tick();
    rst = 1'b0;

    // 1: single op req0 a=1 b=0 -> data 0, busy for 13 cycles
    tick();
    set_req(0, 1'b1, 1, 0);
    @(negedge clk);
    check("t1_ready", req_ready, 3'b001);
    check("t1_busy_before", busy, 0);
    tick();
    req_valid = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check("t1_busy", busy, (k <= 13) ? 1 : 0);
    end
    check("t1_drained", sb.size(), 0);

`ifndef MO_MUL_ARB_FIXPRIO_EN
    // 2: all valid from reset -> grants 0,1,2,0,1,2...
    do_reset();
    set_req(0, 1'b1, 1234, 2345);
    set_req(1, 1'b1, 3328, 3328);
    set_req(2, 1'b1, 3329, 5);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("t2_grant", req_ready, 1 << (k % 3));
      tick();
    end
    req_valid = '0;
    wait_drain("t2_drain");

    // 3: ptr=0, req0 and req2 valid -> grant 2,0,2,0...
    do_reset();
    set_req(0, 1'b1, 7, 11);
    tick();
    req_valid = '0;
    set_req(0, 1'b1, 100, 200);
    set_req(2, 1'b1, 3000, 17);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t3_grant", req_ready, (k % 2 == 0) ? 3'b100 : 3'b001);
      tick();
    end
    req_valid = '0;
    wait_drain("t3_drain");
`else
    // 5: fixed priority, req0 starves req1 until it drops
    do_reset();
    set_req(0, 1'b1, 55, 66);
    set_req(1, 1'b1, 77, 88);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t5_grant", req_ready, 3'b001);
      tick();
    end
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("t5_req1", req_ready, 3'b010);
    tick();
    req_valid = '0;
    wait_drain("t5_drain");
`endif

    // 4: reset 4 cycles after 3 accepts; stale products never reported
    set_req(0, 1'b1, 10, 20);
    set_req(1, 1'b1, 30, 40);
    set_req(2, 1'b1, 50, 60);
    repeat (3) tick();
    req_valid = '0;
    repeat (4) tick();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("t4_rsp_quiet", rsp_valid, 0);
      check("t4_busy_quiet", busy, 0);
    end
    tick();
    set_req(1, 1'b1, 2000, 3000);
    tick();
    req_valid = '0;
    wait_drain("t4_post_drain");

    // 6: random traffic, 10k ops
    tick();
    target = n_acc + 10000;
    guard  = 0;
    while (n_acc < target && guard < 40000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || acc_mask[i]) begin
          set_req(i, ($urandom_range(0, 3) != 0), int'($urandom_range(0, Q - 1)), int'($urandom_range(0, Q - 1)));
        end
      end
      tick();
      guard++;
    end
    req_valid = '0;
    check("t6_ops_done", (n_acc >= target) ? 1 : 0, 1);
    wait_drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
